// File: rtl/esm_core_oim.sv
// esm_core_oim: slot buffer with lowest-free allocation on write and
// random-index drain. An occupancy bitmap tracks live slots; a
// registered population count drives full/empty/in_ready so
// back-pressure never depends on a same-cycle drain.
module esm_core_oim #(
  parameter  int BS = 16,
  parameter  int DW = 8,
  localparam int BB = $clog2(BS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          ready_valid,
  output logic [BB-1:0] ready_index,
  input  logic          rd_valid,
  input  logic [BB-1:0] rd_index,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [BB-1:0] out_index,
  output logic          rd_err,
  output logic [BB:0]   count,
  output logic          full,
  output logic          empty
);

  logic [BS-1:0] occ_q, occ_d;
  logic [BB:0]   count_q, count_d;
  logic [DW-1:0] mem [BS];

  logic          ready_valid_q;
  logic [BB-1:0] ready_index_q;
  logic          out_valid_q;
  logic [DW-1:0] out_data_q;
  logic [BB-1:0] out_index_q;
  logic          rd_err_q;

  logic [BB-1:0] free_idx;
  logic          wr_acc;
  logic          drain_ok;
  logic          drain_bad;

  // Status flags come from registered state only.
  assign full     = (count_q == (BB+1)'(BS));
  assign empty    = (count_q == '0);
  assign in_ready = !full;

  // Handshake qualification against pre-edge occupancy.
  assign wr_acc    = in_valid && in_ready;
  assign drain_ok  = rd_valid &&  occ_q[rd_index];
  assign drain_bad = rd_valid && !occ_q[rd_index];

  // Lowest-numbered free slot; scanning downward leaves the lowest hit.
  always_comb begin
    free_idx = '0;
    for (int i = BS - 1; i >= 0; i--) begin
      if (!occ_q[i]) free_idx = BB'(i);
    end
  end

  // Next occupancy and count; the freed and allocated slots never coincide
  // because allocation only considers slots that are empty before the edge.
  always_comb begin
    occ_d = occ_q;
    if (wr_acc)   occ_d[free_idx] = 1'b1;
    if (drain_ok) occ_d[rd_index] = 1'b0;
    count_d = count_q + (BB+1)'(wr_acc) - (BB+1)'(drain_ok);
  end

  // Control state and output pulses; reset discards everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q         <= '0;
      count_q       <= '0;
      ready_valid_q <= 1'b0;
      ready_index_q <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_index_q   <= '0;
      rd_err_q      <= 1'b0;
    end else begin
      occ_q         <= occ_d;
      count_q       <= count_d;
      ready_valid_q <= wr_acc;
      if (wr_acc) ready_index_q <= free_idx;
      out_valid_q   <= drain_ok;
      rd_err_q      <= drain_bad;
      if (drain_ok) begin
        out_data_q  <= mem[rd_index];
        out_index_q <= rd_index;
      end
    end
  end

  // Slot storage needs no reset; a slot is only read once it is occupied.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[free_idx] <= in_data;
  end

  assign count       = count_q;
  assign ready_valid = ready_valid_q;
  assign ready_index = ready_index_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_index   = out_index_q;
  assign rd_err      = rd_err_q;

endmodule

// File: tb/tb_esm_core_oim.sv
// Directed bench for esm_core_oim with BS=16, DW=8.
module tb_esm_core_oim;

  localparam int BS = 16;
  localparam int DW = 8;
  localparam int BB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          ready_valid;
  logic [BB-1:0] ready_index;
  logic          rd_valid;
  logic [BB-1:0] rd_index;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [BB-1:0] out_index;
  logic          rd_err;
  logic [BB:0]   count;
  logic          full;
  logic          empty;

  int errors = 0;
  int checks = 0;

  esm_core_oim #(.BS(BS), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ready_valid(ready_valid), .ready_index(ready_index),
    .rd_valid(rd_valid), .rd_index(rd_index),
    .out_valid(out_valid), .out_data(out_data), .out_index(out_index),
    .rd_err(rd_err), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; rd_valid = 1'b0; rd_index = '0;
    tick(); tick();
    // Reset state
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ready_valid", ready_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rd_err", rd_err, 0);
    chk("rst_ready_index", ready_index, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b0;
    tick();

    // Drain of an empty block
    rd_valid = 1'b1; rd_index = 4'd3;
    tick();
    rd_valid = 1'b0;
    chk("err_rd_err", rd_err, 1);
    chk("err_out_valid", out_valid, 0);
    chk("err_count", count, 0);
    tick();
    chk("err_pulse_end", rd_err, 0);

    // Fill all 16 slots in order
    for (int i = 0; i < BS; i++) begin
      in_valid = 1'b1; in_data = 8'hA0 + 8'(i);
      tick();
      chk("fill_ready_valid", ready_valid, 1);
      chk("fill_ready_index", ready_index, i);
    end
    in_valid = 1'b0;
    chk("fill_full", full, 1);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_count", count, 16);
    tick();
    chk("fill_idle_ready_valid", ready_valid, 0);
    chk("fill_idle_ready_index", ready_index, 15);

    // Drain slot 5 then refill it
    rd_valid = 1'b1; rd_index = 4'd5;
    tick();
    rd_valid = 1'b0;
    chk("drain5_out_valid", out_valid, 1);
    chk("drain5_out_data", out_data, 8'hA5);
    chk("drain5_out_index", out_index, 5);
    chk("drain5_count", count, 15);
    chk("drain5_in_ready", in_ready, 1);
    tick();
    chk("drain5_pulse_end", out_valid, 0);
    chk("drain5_data_hold", out_data, 8'hA5);
    in_valid = 1'b1; in_data = 8'h55;
    tick();
    in_valid = 1'b0;
    chk("refill_ready_valid", ready_valid, 1);
    chk("refill_ready_index", ready_index, 5);
    chk("refill_full", full, 1);

    // Full with simultaneous drain of slot 9: write stalls one cycle
    in_valid = 1'b1; in_data = 8'h99; rd_valid = 1'b1; rd_index = 4'd9;
    tick();
    rd_valid = 1'b0;
    chk("fulld_out_valid", out_valid, 1);
    chk("fulld_out_data", out_data, 8'hA9);
    chk("fulld_no_accept", ready_valid, 0);
    chk("fulld_count", count, 15);
    chk("fulld_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("fulld_ready_valid", ready_valid, 1);
    chk("fulld_ready_index", ready_index, 9);
    chk("fulld_count2", count, 16);

    // Stored data round-trips through the refilled slots
    rd_valid = 1'b1; rd_index = 4'd9;
    tick();
    chk("rt9_out_data", out_data, 8'h99);
    rd_index = 4'd5;
    tick();
    chk("rt5_out_data", out_data, 8'h55);
    chk("rt5_out_index", out_index, 5);
    // Slot 5 now empty: repeat drain errors without state change
    tick();
    rd_valid = 1'b0;
    chk("rt5_again_err", rd_err, 1);
    chk("rt5_again_out_valid", out_valid, 0);
    chk("rt5_again_count", count, 14);

    // Simultaneous write and drain with 4 occupied slots
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'h10 + 8'(i);
      tick();
    end
    chk("sim_pre_count", count, 4);
    in_data = 8'h77; rd_valid = 1'b1; rd_index = 4'd1;
    tick();
    in_valid = 1'b0; rd_valid = 1'b0;
    chk("sim_ready_valid", ready_valid, 1);
    chk("sim_ready_index", ready_index, 4);
    chk("sim_out_valid", out_valid, 1);
    chk("sim_out_index", out_index, 1);
    chk("sim_out_data", out_data, 8'h11);
    chk("sim_count", count, 4);
    in_valid = 1'b1; in_data = 8'h88;
    tick();
    in_valid = 1'b0;
    chk("sim_reuse_index", ready_index, 1);
    chk("sim_reuse_count", count, 5);
    rd_valid = 1'b1; rd_index = 4'd4;
    tick();
    rd_valid = 1'b0;
    chk("sim_slot4_data", out_data, 8'h77);

    // Reset asserted during a drain with 6 occupied slots
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 8'h20 + 8'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("mid_pre_count", count, 6);
    rd_valid = 1'b1; rd_index = 4'd2; rst = 1'b1;
    tick();
    rst = 1'b0; rd_valid = 1'b0;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_count", count, 0);
    chk("mid_empty", empty, 1);
    tick();
    chk("mid_no_pulse_out", out_valid, 0);
    chk("mid_no_pulse_err", rd_err, 0);
    in_valid = 1'b1; in_data = 8'h31;
    tick();
    in_valid = 1'b0;
    chk("mid_first_ready_valid", ready_valid, 1);
    chk("mid_first_index", ready_index, 0);
    rd_valid = 1'b1; rd_index = 4'd0;
    tick();
    rd_valid = 1'b0;
    chk("mid_first_data", out_data, 8'h31);
    chk("mid_final_empty", empty, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/esm_core_oim.md
ESM_CORE_OIM -- requirements
Module: esm_core_oim

Interface
REQ-001 Parameter BS, default 16, number of buffer slots; SHALL be a power of two, 2..64.
REQ-002 Parameter DW, default 8, data width of one slot.
REQ-003 Derived constant BB = clog2(BS), index width.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  writer offers in_data.
REQ-007 in_ready  output  1  slot available for a write.
REQ-008 in_data  input  DW  write data.
REQ-009 ready_valid  output  1  one-cycle pulse: a slot was just filled.
REQ-010 ready_index  output  BB  index of the slot just filled.
REQ-011 rd_valid  input  1  drain request.
REQ-012 rd_index  input  BB  slot to drain (the randomly selected buffer index).
REQ-013 out_valid  output  1  one-cycle pulse: out_data/out_index valid.
REQ-014 out_data  output  DW  drained data.
REQ-015 out_index  output  BB  drained slot index.
REQ-016 rd_err  output  1  one-cycle pulse: drain of an empty slot.
REQ-017 count  output  BB+1  number of occupied slots.
REQ-018 full / empty  output  1 each  count==BS / count==0.

Function
REQ-019 The block SHALL hold a BS-bit occupancy bitmap occ and a BS x DW data array mem.
REQ-020 in_ready SHALL equal !full, derived combinationally from registered occ only, never from same-cycle rd_valid.
REQ-021 Write accept occurs when in_valid && in_ready at a rising edge; the allocated slot SHALL be the lowest-numbered index with occ==0 at that edge.
REQ-022 On write accept: mem[slot] <= in_data; occ[slot] <= 1; next cycle ready_valid=1, ready_index=slot (latency 1).
REQ-023 With no accept, ready_valid SHALL be 0; ready_index SHALL hold its last value.
REQ-024 Drain: rd_valid with occ[rd_index]==1 at an edge SHALL produce, next cycle, out_valid=1, out_data=mem[rd_index], out_index=rd_index, with occ[rd_index] cleared at that edge.
REQ-025 rd_valid with occ[rd_index]==0 SHALL produce rd_err=1 next cycle, out_valid=0, with no state change.
REQ-026 out_valid and rd_err SHALL be 0 in every cycle not covered by REQ-024/025; out_data/out_index SHALL hold their last values.
REQ-027 Simultaneous write accept and valid drain: both SHALL take effect at the same edge; count unchanged.
REQ-028 A slot freed by a drain SHALL NOT be allocated by a write at the same edge; allocation uses pre-edge occ.
REQ-029 Drain and write targeting the same slot at the same edge cannot occur (REQ-028); a drain always reads pre-edge mem contents.
REQ-030 When full, writes SHALL stall (in_ready=0) even if a drain occurs that cycle; in_ready rises the following cycle.
REQ-031 count SHALL equal popcount(occ) at all times, registered, updated at the same edge as occ.
REQ-032 The block SHALL never drop or duplicate accepted data; every accepted write SHALL appear exactly once at out_data after its slot is drained.

Reset
REQ-033 While rst=1: occ=0, count=0, empty=1, full=0, in_ready=1, ready_valid=0, out_valid=0, rd_err=0, ready_index=0, out_index=0, out_data=0.
REQ-034 mem contents SHALL NOT require reset; they are unobservable until written.
REQ-035 Reset asserted mid-operation SHALL discard all stored data immediately; any write or drain in that cycle SHALL be lost, with no pulses after rst deasserts.
REQ-036 The first write accepted after reset SHALL allocate slot 0.

Verification
REQ-037 Fill: BS=16, 16 consecutive writes 0xA0..0xAF -> ready_index 0..15 in order, one cycle after each accept; then full=1, in_ready=0, count=16.
REQ-038 Drain: after fill, rd_index=5 -> next cycle out_valid=1, out_data=0xA5, out_index=5, count=15; next write 0x55 -> ready_index=5.
REQ-039 Error: empty block, rd_valid with rd_index=3 -> rd_err=1 for one cycle, out_valid=0, count=0.
REQ-040 Simultaneous: 4 slots filled (0..3), same-cycle write 0x77 and drain of slot 1 -> write lands in slot 4, out_index=1, count stays 4.
REQ-041 Full+drain: full, same-cycle in_valid and drain of slot 9 -> write not accepted that cycle; next cycle in_ready=1 and the write fills slot 9.
REQ-042 Reset mid-stream: 6 slots occupied, rst pulsed during a drain request -> no out_valid, count=0, empty=1; next write gets ready_index=0.
